// File: rtl/debounce_multi.sv
// N-channel button conditioner: 2-FF sync, per-channel debounce counter, and
// a hold FSM that emits press/release/long/auto-repeat single-cycle strobes.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | debounced level is 0, hold counter idle
// S_WAIT_LONG | level is 1, counting towards the long-press strobe
// S_REPEAT    | long strobe issued, emitting repeat strobes periodically
// S_DONE      | long strobe issued and repeat disabled, waiting for fall
module debounce_multi #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned ACTIVE_LOW     = 0,
  parameter int unsigned CNT_W          = 23,
  parameter int unsigned DEBOUNCE_COUNT = 5_000_000,
  parameter int unsigned HOLD_W         = 28,
  parameter int unsigned LONG_COUNT     = 100_000_000,
  parameter int unsigned REPEAT_COUNT   = 20_000_000
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [N_CH-1:0] button_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_COUNT - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_COUNT - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  =
    (REPEAT_COUNT == 0) ? '0 : HOLD_W'(REPEAT_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_LONG,
    S_REPEAT,
    S_DONE
  } hold_state_t;

  logic [N_CH-1:0] pin;

  assign pin = (ACTIVE_LOW != 0) ? ~button_in : button_in;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic              sync0, sync1, level;
    logic              accept, rise, fall;
    logic              press_q, release_q, long_q, repeat_q;
    logic              long_nxt, repeat_nxt;
    logic [CNT_W-1:0]  db_cnt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    hold_state_t       state, state_nxt;

    // Accept a change only when the mismatch has persisted for the full count.
    assign accept = (sync1 != level) && (db_cnt == DB_LAST);
    assign rise   = accept && sync1;
    assign fall   = accept && !sync1;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        sync0     <= 1'b0;
        sync1     <= 1'b0;
        level     <= 1'b0;
        db_cnt    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync0     <= pin[i];
        sync1     <= sync0;
        press_q   <= rise;
        release_q <= fall;
        if (sync1 == level) begin
          db_cnt <= '0;
        end else if (accept) begin
          level  <= sync1;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        state    <= S_IDLE;
        hold_cnt <= '0;
        long_q   <= 1'b0;
        repeat_q <= 1'b0;
      end else begin
        state    <= state_nxt;
        hold_cnt <= hold_cnt_nxt;
        long_q   <= long_nxt;
        repeat_q <= repeat_nxt;
      end
    end

    // An accepted fall overrides everything, so no hold strobe can share its cycle.
    always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      if (fall) begin
        state_nxt    = S_IDLE;
        hold_cnt_nxt = '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (rise) begin
              state_nxt    = S_WAIT_LONG;
              hold_cnt_nxt = '0;
            end
          end
          S_WAIT_LONG: begin
            if (hold_cnt == LONG_LAST) begin
              state_nxt    = (REPEAT_COUNT == 0) ? S_DONE : S_REPEAT;
              hold_cnt_nxt = '0;
            end else begin
              hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
          end
          S_REPEAT: begin
            if (hold_cnt == REP_LAST) hold_cnt_nxt = '0;
            else                      hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
          S_DONE: begin
            hold_cnt_nxt = hold_cnt;
          end
          default: begin
            state_nxt    = S_IDLE;
            hold_cnt_nxt = '0;
          end
        endcase
      end
    end

    always_comb begin
      long_nxt   = 1'b0;
      repeat_nxt = 1'b0;
      if (!fall) begin
        long_nxt   = (state == S_WAIT_LONG) && (hold_cnt == LONG_LAST);
        repeat_nxt = (state == S_REPEAT) && (hold_cnt == REP_LAST);
      end
    end

    assign level_out[i]     = level;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign long_pulse[i]    = long_q;
    assign repeat_pulse[i]  = repeat_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus queues expected strobes with
// their edge numbers, a monitor matches every observed strobe against them.
module tb_debounce_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst_a, nrst_b;
  logic [1:0] btn_a, btn_b;
  logic [1:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
  logic [1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;

  debounce_multi #(
    .N_CH(2), .ACTIVE_LOW(0), .CNT_W(23), .DEBOUNCE_COUNT(4),
    .HOLD_W(28), .LONG_COUNT(10), .REPEAT_COUNT(3)
  ) dut_a (
    .clk(clk), .nrst(nrst_a), .button_in(btn_a),
    .level_out(lvl_a), .press_pulse(prs_a), .release_pulse(rel_a),
    .long_pulse(lng_a), .repeat_pulse(rep_a)
  );

  debounce_multi #(
    .N_CH(2), .ACTIVE_LOW(1), .CNT_W(23), .DEBOUNCE_COUNT(4),
    .HOLD_W(28), .LONG_COUNT(10), .REPEAT_COUNT(0)
  ) dut_b (
    .clk(clk), .nrst(nrst_b), .button_in(btn_b),
    .level_out(lvl_b), .press_pulse(prs_b), .release_pulse(rel_b),
    .long_pulse(lng_b), .repeat_pulse(rep_b)
  );

  typedef struct {
    int e;
    int inst;
    int ch;
    int kind;
  } ev_t;

  ev_t sb[$];
  int  total  = 0;
  int  bad    = 0;
  int  edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic string kname(int k);
    case (k)
      0:       return "press";
      1:       return "release";
      2:       return "long";
      default: return "repeat";
    endcase
  endfunction

  task automatic expect_ev(int e, int inst, int ch, int kind);
    ev_t x;
    x.e = e; x.inst = inst; x.ch = ch; x.kind = kind;
    sb.push_back(x);
  endtask

  task automatic chk(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, expv, edge_n);
    end
  endtask

  task automatic wait_to(int e);
    while (edge_n < e) @(negedge clk);
  endtask

  // Monitor: each strobe seen must match a queued expectation at this edge.
  always @(negedge clk) begin
    logic [1:0] s [2][4];
    int idx;
    s[0][0] = prs_a; s[0][1] = rel_a; s[0][2] = lng_a; s[0][3] = rep_a;
    s[1][0] = prs_b; s[1][1] = rel_b; s[1][2] = lng_b; s[1][3] = rep_b;
    for (int inst = 0; inst < 2; inst++)
      for (int kind = 0; kind < 4; kind++)
        for (int ch = 0; ch < 2; ch++)
          if (s[inst][kind][ch]) begin
            total++;
            idx = -1;
            foreach (sb[k])
              if (idx < 0 && sb[k].e == edge_n && sb[k].inst == inst &&
                  sb[k].ch == ch && sb[k].kind == kind) idx = k;
            if (idx >= 0) sb.delete(idx);
            else begin
              bad++;
              $display("FAIL strobe %s inst%0d ch%0d: seen at edge %0d, none expected",
                       kname(kind), inst, ch, edge_n);
            end
          end
  end

  initial begin
    int n, p;
    nrst_a = 1'b0; nrst_b = 1'b0;
    btn_a  = 2'b11; btn_b = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset_a_outputs", {rep_a, lng_a, rel_a, prs_a, lvl_a}, 0);
    chk("reset_b_outputs", {rep_b, lng_b, rel_b, prs_b, lvl_b}, 0);

    // Reset release with both inputs already high: accept at edge 5 after release.
    n = edge_n;
    nrst_a = 1'b1; nrst_b = 1'b1;
    expect_ev(n + 6, 0, 0, 0);
    expect_ev(n + 6, 0, 1, 0);
    wait_to(n + 5);  chk("rst_rise_before", lvl_a, 2'b00);
    wait_to(n + 6);  chk("rst_rise_at", lvl_a, 2'b11);
    btn_a = 2'b00;
    expect_ev(n + 12, 0, 0, 1);
    expect_ev(n + 12, 0, 1, 1);
    wait_to(n + 11); chk("rst_fall_before", lvl_a, 2'b11);
    wait_to(n + 12); chk("rst_fall_at", lvl_a, 2'b00);
    chk("active_low_idle", lvl_b, 2'b00);

    // Glitch of three samples on ch0: rejected.
    wait_to(edge_n + 4);
    n = edge_n;
    btn_a[0] = 1'b1;
    wait_to(n + 3);  btn_a[0] = 1'b0;
    wait_to(n + 12); chk("glitch3_level", lvl_a, 2'b00);

    // Four samples on ch0: accepted, then released.
    n = edge_n;
    btn_a[0] = 1'b1;
    expect_ev(n + 6, 0, 0, 0);
    expect_ev(n + 10, 0, 0, 1);
    wait_to(n + 4);  btn_a[0] = 1'b0;
    wait_to(n + 5);  chk("pulse4_before", lvl_a, 2'b00);
    wait_to(n + 6);  chk("pulse4_accept", lvl_a, 2'b01);
    wait_to(n + 10); chk("pulse4_release", lvl_a, 2'b00);

    // Long press and auto-repeat on ch1; the fall edge coincides with a repeat slot.
    wait_to(edge_n + 4);
    n = edge_n;
    p = n + 6;
    btn_a[1] = 1'b1;
    expect_ev(p, 0, 1, 0);
    expect_ev(p + 10, 0, 1, 2);
    for (int k = 13; k <= 28; k += 3) expect_ev(p + k, 0, 1, 3);
    expect_ev(p + 31, 0, 1, 1);
    wait_to(p + 25); btn_a[1] = 1'b0;
    wait_to(p + 30); chk("long_hold_level", lvl_a, 2'b10);
    wait_to(p + 31); chk("long_fall_level", lvl_a, 2'b00);
    wait_to(p + 36);

    // Release on ch0 landing exactly where the long strobe would fire.
    n = edge_n;
    p = n + 6;
    btn_a[0] = 1'b1;
    expect_ev(p, 0, 0, 0);
    expect_ev(p + 10, 0, 0, 1);
    wait_to(p + 4);  btn_a[0] = 1'b0;
    wait_to(p + 14); chk("short_hold_level", lvl_a, 2'b00);

    // Both channels rise together; ch1 bounces once and is delayed by its own counter.
    n = edge_n;
    btn_a = 2'b11;
    expect_ev(n + 6, 0, 0, 0);
    expect_ev(n + 9, 0, 1, 0);
    wait_to(n + 2);  btn_a[1] = 1'b0;
    wait_to(n + 3);  btn_a[1] = 1'b1;
    wait_to(n + 6);  chk("simul_ch0_first", lvl_a, 2'b01);
    wait_to(n + 8);  chk("simul_ch1_late", lvl_a, 2'b01);
    wait_to(n + 9);  chk("simul_both", lvl_a, 2'b11);
    btn_a = 2'b00;
    expect_ev(n + 15, 0, 0, 1);
    expect_ev(n + 15, 0, 1, 1);
    wait_to(n + 20);

    // Active-low instance with repeat disabled: single long strobe, then reset mid-hold.
    n = edge_n;
    p = n + 6;
    btn_b[0] = 1'b0;
    expect_ev(p, 1, 0, 0);
    expect_ev(p + 10, 1, 0, 2);
    wait_to(p + 20); chk("al_hold_level", lvl_b, 2'b01);
    nrst_b = 1'b0;
    #1;
    chk("al_midhold_reset", {rep_b, lng_b, rel_b, prs_b, lvl_b}, 0);
    btn_b = 2'b11;
    @(negedge clk);
    nrst_b = 1'b1;
    wait_to(edge_n + 10);
    chk("al_after_reset", lvl_b, 2'b00);

    repeat (5) @(negedge clk);
    foreach (sb[k]) begin
      total++;
      bad++;
      $display("FAIL missing %s inst%0d ch%0d: not seen, required at edge %0d",
               kname(sb[k].kind), sb[k].inst, sb[k].ch, sb[k].e);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
